// File: rtl/nd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// nd_pkg : shared types and chunk arithmetic for nonce_dispatcher
// Rev 1.0
// ------------------------------------------------------------------
package nd_pkg;

  localparam int NONCE_W = 32;
  localparam int MID_W   = 256;
  localparam int DATA_W  = 96;
  localparam int JOB_W   = MID_W + DATA_W + 2 * NONCE_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  // Last nonce of the chunk starting at next, clipped to max; 33-bit so FFFFFFFF never wraps.
  function automatic logic [NONCE_W:0] chunk_end(input logic [NONCE_W:0]   next,
                                                 input logic [NONCE_W-1:0] max,
                                                 input int                 log2);
    logic [NONCE_W:0] one;
    logic [NONCE_W:0] last;
    one  = {{NONCE_W{1'b0}}, 1'b1};
    last = next + ((one << log2) - one);
    return (last > {1'b0, max}) ? {1'b0, max} : last;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nd_result_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// nd_result_fifo : first-word-fall-through FIFO, push+pop allowed when full
// Rev 1.0
// ------------------------------------------------------------------
module nd_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == C_DEPTH);
  assign empty    = (count_q == '0);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nonce_dispatcher.sv
`default_nettype none
// ------------------------------------------------------------------
// nonce_dispatcher : splits a job's nonce range into chunks for hash cores
// and collects golden nonces round-robin into a result FIFO. Rev 1.0
// ------------------------------------------------------------------
module nonce_dispatcher
  import nd_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CHUNK_LOG2 = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           hash_clk,
  input  logic                           reset_n,
  input  logic                           tx_new_work,
  input  logic [MID_W-1:0]               tx_midstate,
  input  logic [DATA_W-1:0]              tx_data,
  input  logic [NONCE_W-1:0]             tx_nonce_min,
  input  logic [NONCE_W-1:0]             tx_nonce_max,
  output logic [MID_W-1:0]               core_midstate,
  output logic [DATA_W-1:0]              core_data,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NONCE_W-1:0]             core_nonce_lo,
  output logic [NONCE_W-1:0]             core_nonce_hi,
  output logic                           core_abort,
  input  logic [NUM_CORES-1:0]           core_busy,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
  output logic [NONCE_W-1:0]             golden_nonce,
  output logic                           golden_valid,
  input  logic                           golden_ready,
  output logic                           job_done,
  output logic                           drop_flag
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t               state_q, state_d;
  logic [JOB_W-1:0]     job_q, job_d;
  logic [NONCE_W:0]     next_q, next_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [NONCE_W-1:0]   lo_q, lo_d;
  logic [NONCE_W-1:0]   hi_q, hi_d;
  logic                 abort_q, abort_d;
  logic                 done_q, done_d;
  logic [NUM_CORES-1:0] pend_v_q, pend_v_d;
  logic [NONCE_W-1:0]   pend_n_q [NUM_CORES];
  logic [NONCE_W-1:0]   pend_n_d [NUM_CORES];
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic                 drop_q, drop_d;

  logic [NONCE_W-1:0]   min_w, max_w;
  logic [NONCE_W:0]     chunk_hi;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Job word layout: {midstate, data, min, max}
  assign min_w         = job_q[2*NONCE_W-1:NONCE_W];
  assign max_w         = job_q[NONCE_W-1:0];
  assign core_midstate = job_q[JOB_W-1 -: MID_W];
  assign core_data     = job_q[2*NONCE_W +: DATA_W];
  assign core_start    = start_q;
  assign core_nonce_lo = lo_q;
  assign core_nonce_hi = hi_q;
  assign core_abort    = abort_q;
  assign job_done      = done_q;
  assign drop_flag     = drop_q;
  assign golden_valid  = !fifo_empty;
  assign chunk_hi      = chunk_end(next_q, max_w, CHUNK_LOG2);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    // A core started last cycle has not raised busy yet, so it is skipped too.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!sel_found && !core_busy[i] && !start_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    state_d = state_q;
    job_d   = job_q;
    next_d  = next_q;
    start_d = '0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    abort_d = 1'b0;
    done_d  = 1'b0;

    if (tx_new_work) begin
      abort_d = 1'b1;
      job_d   = {tx_midstate, tx_data, tx_nonce_min, tx_nonce_max};
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          next_d = {1'b0, min_w};
          if (min_w > max_w) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (next_q > {1'b0, max_w}) begin
            state_d = ST_DRAIN;
          end else if (sel_found) begin
            start_d = NUM_CORES'(1) << sel_idx;
            lo_d    = next_q[NONCE_W-1:0];
            hi_d    = chunk_hi[NONCE_W-1:0];
            next_d  = chunk_hi + (NONCE_W+1)'(1);
          end
        end
        ST_DRAIN: begin
          if (core_busy == '0 && start_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_found && pend_v_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end

    fifo_pop  = golden_valid && golden_ready;
    fifo_push = grant_found && (!fifo_full || fifo_pop) && !tx_new_work;

    pend_v_d = pend_v_q;
    pend_n_d = pend_n_q;
    drop_d   = drop_q;
    rr_d     = rr_q;

    if (fifo_push) begin
      rr_d = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + IDX_W'(1);
    end

    // Clear the winner before accepting new finds so a slot can refill the cycle it drains.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (fifo_push && grant_idx == IDX_W'(i)) pend_v_d[i] = 1'b0;
      if (core_found[i]) begin
        if (pend_v_d[i]) begin
          drop_d = 1'b1;
        end else begin
          pend_v_d[i] = 1'b1;
          pend_n_d[i] = core_nonce[i*NONCE_W +: NONCE_W];
        end
      end
    end

    if (tx_new_work) begin
      pend_v_d = '0;
      drop_d   = 1'b0;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      job_q    <= '0;
      next_q   <= '0;
      start_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      pend_v_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        pend_n_q[i] <= '0;
      end
      rr_q     <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      next_q   <= next_d;
      start_q  <= start_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      pend_v_q <= pend_v_d;
      pend_n_q <= pend_n_d;
      rr_q     <= rr_d;
      drop_q   <= drop_d;
    end
  end

  nd_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_result_fifo (
    .clk       (hash_clk),
    .rst_n     (reset_n),
    .flush     (tx_new_work),
    .push      (fifo_push),
    .push_data (pend_n_q[grant_idx]),
    .pop       (fifo_pop),
    .pop_data  (golden_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Sits in the hash_clk domain between the UART comm block's job outputs and NUM_CORES SHA-256 hash cores.
- Splits each job's inclusive nonce range into fixed-size chunks and hands them to idle cores.
- Aborts all cores when new work arrives.
- Arbitrates golden-nonce reports round-robin into a small FIFO, drained by a valid/ready handshake toward the comm block.

Parameters:
NUM_CORES, 4, number of hash cores (1..16)
CHUNK_LOG2, 24, chunk size = 2^CHUNK_LOG2 nonces
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
hash_clk  in  1  hash clock domain
reset_n  in  1  asynchronous active-low reset
tx_new_work  in  1  one-cycle pulse: job inputs valid
tx_midstate  in  256  job midstate
tx_data  in  96  job tail data
tx_nonce_min  in  32  first nonce (inclusive)
tx_nonce_max  in  32  last nonce (inclusive)
core_midstate  out  256  broadcast midstate (registered copy)
core_data  out  96  broadcast tail data
core_start  out  NUM_CORES  one-cycle start pulse per core
core_nonce_lo  out  32  chunk first nonce, valid with any core_start
core_nonce_hi  out  32  chunk last nonce, valid with any core_start
core_abort  out  1  one-cycle pulse: all cores stop
core_busy  in  NUM_CORES  core working on a chunk
core_found  in  NUM_CORES  one-cycle pulse: core has a golden nonce
core_nonce  in  32*NUM_CORES  per-core nonce, valid with core_found
golden_nonce  out  32  FIFO head
golden_valid  out  1  FIFO non-empty
golden_ready  in  1  consumer pops head when valid&ready
job_done  out  1  one-cycle pulse: range exhausted, all cores idle
drop_flag  out  1  sticky: a result was lost; cleared by tx_new_work

Behaviour:
- Reset: all outputs 0; FIFO empty; pending regs empty; state IDLE; round-robin pointer 0.
- States: IDLE, LOAD, DISPATCH, DRAIN.
- Any state, tx_new_work:
  - core_abort pulses next cycle.
  - Midstate, data, min and max are latched.
  - FIFO and pending regs are flushed; drop_flag is cleared.
  - Next state is LOAD. New work overrides all other activity that cycle.
- LOAD (1 cycle):
  - next_nonce (33-bit) <= {0, min}.
  - If min > max: pulse job_done, go to IDLE, no dispatch. Otherwise go to DISPATCH.
- DISPATCH:
  - At most one core started per cycle: the lowest-index core with core_busy=0 that was not started in the previous cycle (cores raise busy one cycle after start).
  - Chunk bounds: lo = next_nonce[31:0]; hi = min(next_nonce + 2^CHUNK_LOG2 - 1, max), computed in 33 bits.
  - After each start: next_nonce <= hi + 1 (33-bit, so max = FFFFFFFF never wraps).
  - When next_nonce > max: go to DRAIN.
- DRAIN: when all core_busy=0 and no start in the last cycle, pulse job_done and go to IDLE.
- Result path runs independently of the state machine:
  - Each core has a 1-entry pending register, set by core_found.
  - Each cycle, a round-robin arbiter moves one pending entry into the FIFO if the FIFO is not full (or is being popped that cycle). The pointer advances past the winner.
  - core_found while that core's pending entry is still full: the new nonce is dropped and drop_flag is set. The pending register refills the same cycle it empties.
  - FIFO is first-word-fall-through; golden_nonce is stable while golden_valid && !golden_ready.
- Reset mid-operation clears everything asynchronously. No core_abort pulse is produced; cores share reset_n.

Decomposition:
- Shared package nd_pkg: state encodings, JOB_W=416, NONCE_W=32, and a function for the chunk-end computation.
- One natural sub-module: nd_result_fifo (parameterised FWFT FIFO with full/empty, simultaneous push/pop supported at full).

Test Plan:
- NUM_CORES=4, CHUNK_LOG2=4, min=0, max=63, cores busy 10 cycles → four starts with lo/hi 0/15, 16/31, 32/47, 48/63; then one job_done.
- min=FFFFFFF0, max=FFFFFFFF, CHUNK_LOG2=24 → single start with lo=FFFFFFF0, hi=FFFFFFFF; job_done; no further starts (no wrap).
- min=10, max=5 → job_done two cycles after tx_new_work; zero core_start.
- core_found on cores 0..3 in the same cycle with nonces 0xA0..0xA3, golden_ready=1 → FIFO outputs A0, A1, A2, A3 in consecutive cycles; drop_flag=0.
- golden_ready=0, core 1 fires 6 times (FIFO_DEPTH=4) → 4 entries in FIFO plus 1 pending; 6th fire sets drop_flag; a later tx_new_work clears FIFO and drop_flag.
- tx_new_work during DISPATCH → core_abort pulse next cycle; dispatch restarts from the new min; no results from the old job are emitted.
